hp_burst_reader: RTL and testbench
==================================

# hp_burst_reader

AXI4 read master on a Zynq HP port that fetches a contiguous region of 64-bit words from DDR in INCR bursts and streams them, one burst at a time, into the BRAM staging controller downstream. It splits a transfer into bursts of at most MAX_BURST beats that never cross a 4 KB boundary. It issues one outstanding burst at a time and stalls the R channel whenever the downstream buffer reports full.

## Interface
Parameters:
- ADDR_W, 32, AXI address width
- MAX_BURST, 8, maximum beats per burst; legal range 1..15 because the downstream beat count is 4 bits
- LEN_W, 16, width of the transfer length in 64-bit words

Ports:
- clk  in  1  single clock for all logic
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request, sampled only in IDLE
- base_addr  in  ADDR_W  byte address; bits [2:0] are ignored and treated as 0
- total_beats  in  LEN_W  number of 64-bit words to fetch
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- err  out  1  sticky error flag, cleared by the next accepted start
- m_araddr  out  ADDR_W  burst start address
- m_arlen  out  8  beats-1
- m_arsize  out  3  constant 3'b011 (8 bytes)
- m_arburst  out  2  constant 2'b01 (INCR)
- m_arvalid  out  1  AR valid
- m_arready  in  1  AR ready
- m_rdata  in  64  read data
- m_rresp  in  2  read response
- m_rlast  in  1  last beat of burst
- m_rvalid  in  1  R valid
- m_rready  out  1  R ready
- out_valid  out  1  word valid to the BRAM controller
- out_cnt  out  4  beat count of the current burst, stable for the whole burst
- out_data  out  64  word to the BRAM controller
- out_full  in  1  downstream full; a word is consumed in any cycle with out_valid & !out_full

## Operation
- States: IDLE, ADDR, DATA, DONE.
- IDLE:
  - start with total_beats != 0: latch addr = {base_addr[ADDR_W-1:3], 3'b000} and remaining = total_beats, clear err, go to ADDR.
  - start with total_beats == 0: go directly to DONE.
  - start while not in IDLE is ignored.
- Burst length: beats = min(MAX_BURST, remaining, (4096 - addr[11:0]) >> 3). The value is computed combinationally from registered addr and remaining, and latched into the burst register on entry to ADDR.
- ADDR:
  - m_arvalid = 1, m_araddr = addr, m_arlen = beats-1.
  - Address and length stay stable until m_arready.
  - On handshake, go to DATA and set beat_cnt = 0.
- DATA:
  - Each R handshake (m_rvalid & m_rready) loads the output register and increments beat_cnt.
  - Final beat (beat_cnt == beats-1): addr += beats*8, remaining -= beats. Go to ADDR if remaining != 0, else DONE.
- DONE: wait until the output register is empty, pulse done for one cycle, return to IDLE.
- Output register: a one-entry pipeline stage.
  - m_rready = in_DATA & (!out_valid | !out_full).
  - Loads when m_rready & m_rvalid; clears when consumed and no new load occurs.
- out_cnt updates only when a new burst enters ADDR. It must never change while out_valid is high with data from the previous burst.
- err is set (the transfer still completes) on any of:
  - m_rresp != 2'b00 on any beat;
  - m_rlast high before the final beat;
  - m_rlast low on the final beat.

## Timing
- Reset values:
  - All outputs 0 except m_arsize = 3'b011 and m_arburst = 2'b01.
  - State IDLE; counters 0.
- start in cycle N: busy and m_arvalid go high in cycle N+1.
- The R beat accepted in cycle N appears on out_valid/out_data in cycle N+1.
- Sustained rate is 1 word/cycle while out_full stays low.
- The next AR is issued the cycle after the final R handshake of the previous burst; bursts never overlap.
- out_full held high:
  - out_valid and out_data hold.
  - m_rready drops combinationally once the register is occupied.
  - No beat is lost or duplicated.
- Reset mid-transfer: all state is cleared immediately. Outstanding AXI beats after reset release are not tracked; the system must reset the interconnect together with this block.
- m_arlen never exceeds MAX_BURST-1, and a burst never crosses a 4 KB boundary.

## Structure
- Package hp_pkg holds:
  - the state enum (IDLE, ADDR, DATA, DONE);
  - AXI constants AXI_SIZE_8B = 3'b011, AXI_BURST_INCR = 2'b01, AXI_RESP_OKAY = 2'b00.
- Sub-module hp_out_reg: the one-entry 64-bit output register with its valid/full handshake. It is instantiated once.
- Burst-length calculation and FSM stay in the top module.

## Test plan
- base 0x1000_0000, total_beats 20, MAX_BURST 8, out_full low -> three ARs with arlen 7, 7, 3 at 0x1000_0000, 0x1000_0040, 0x1000_0080; out_cnt 8, 8, 4; 20 words in order; one done pulse; err 0.
- base 0x1000_0FE0, total_beats 10 -> bursts of 4 beats (crossing 4 KB split at 0x1000_1000), 6 beats from 0x1000_1000; data ordered correctly.
- total_beats 8, out_full toggling 3 cycles high / 1 low starting mid-burst -> every word appears exactly once; out_data stable while full; m_rready low whenever register occupied and full.
- Slave returns rresp 2'b10 on beat 3 of 8 -> all 8 words still delivered, done pulses, err 1; next start clears err to 0.
- total_beats 0 -> no AR issued, done pulse 2 cycles after start; start asserted while busy -> ignored, transfer unchanged.
- Assert rst_n low during DATA of burst 2 -> all outputs return to reset values the same cycle; new start after release runs a clean transfer.

Source files
------------

// File: rtl/hp_burst_reader_pkg.sv
// Shared types and constants for the HP-port burst reader.
//   state_t      : controller states (IDLE, ADDR, DATA, DONE)
//   AXI_*        : fixed AXI4 encodings driven or checked by the reader
//   calc_beats() : length of the next burst, bounded by the beat limit,
//                  the words still to fetch and the room left in the 4 KB page
package hp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // word_off is the 64-bit word index inside the current 4 KB page
  // (addr[11:3]), so the page has 512 - word_off words left before the
  // boundary. The result is never 0 while remaining != 0.
  function automatic logic [3:0] calc_beats(input logic [31:0] remaining,
                                            input logic [8:0]  word_off,
                                            input logic [3:0]  max_beats);
    logic [31:0] room;
    logic [3:0]  b;
    room = 32'd512 - 32'(word_off);
    b    = max_beats;
    if (remaining < 32'(b)) b = remaining[3:0];
    if (room < 32'(b))      b = room[3:0];
    return b;
  endfunction

endpackage

// File: rtl/hp_burst_reader_out_reg.sv
// One-entry 64-bit output pipeline stage towards the BRAM staging controller.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   load, load_data      : write a new word (only when ready is high)
//   out_full             : downstream full; word consumed when valid & !full
//   ready                : stage can take a word this cycle
//   out_valid, out_data  : held word presented downstream
module hp_out_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [63:0] load_data,
  input  logic        out_full,
  output logic        ready,
  output logic        out_valid,
  output logic [63:0] out_data
);

  logic        valid_reg;
  logic [63:0] data_reg;

  // Empty, or the held word leaves this cycle: either way a new word fits.
  assign ready     = !valid_reg || !out_full;
  assign out_valid = valid_reg;
  assign out_data  = data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= 64'd0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= load_data;
    end else if (valid_reg && !out_full) begin
      valid_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/hp_burst_reader.sv
// AXI4 read master for a Zynq HP port. Fetches total_beats 64-bit words from
// base_addr in INCR bursts (<= MAX_BURST beats, never crossing 4 KB), one
// burst outstanding at a time, and streams them into a one-entry output stage.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   start, base_addr, total_beats   : transfer request (accepted in IDLE)
//   busy, done, err                 : status (done is a 1-cycle pulse, err sticky)
//   m_ar*                           : AXI read address channel
//   m_r*                            : AXI read data channel
//   out_valid, out_cnt, out_data    : words to the BRAM controller
//   out_full                        : downstream back-pressure
module hp_burst_reader
  import hp_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 8,
  parameter int LEN_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  total_beats,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [63:0]       m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic              out_valid,
  output logic [3:0]        out_cnt,
  output logic [63:0]       out_data,
  input  logic              out_full
);

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [LEN_W-1:0]  remaining_reg, remaining_next;
  logic [3:0]        burst_reg;
  logic [3:0]        beat_cnt_reg;
  logic [3:0]        out_cnt_reg;
  logic              err_reg;
  logic              done_reg;
  logic              load_burst;
  logic              clr_err;
  logic              out_ready;
  logic              r_hs;
  logic              last_beat;
  logic [3:0]        beats_next;
  logic              unused_bits;

  assign unused_bits = ^base_addr[2:0];

  assign r_hs      = m_rvalid && m_rready;
  assign last_beat = (beat_cnt_reg == burst_reg - 4'd1);

  // The burst register is loaded on the same edge that loads addr/remaining,
  // so the length is taken from the values being written, not the old ones.
  assign beats_next = calc_beats(32'(remaining_next), addr_next[11:3], MAX_B);

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    load_burst     = 1'b0;
    clr_err        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          clr_err = 1'b1;
          if (total_beats != '0) begin
            addr_next      = {base_addr[ADDR_W-1:3], 3'b000};
            remaining_next = total_beats;
            load_burst     = 1'b1;
            state_next     = ADDR;
          end else begin
            state_next = DONE;
          end
        end
      end
      ADDR: begin
        if (m_arready) state_next = DATA;
      end
      DATA: begin
        if (r_hs && last_beat) begin
          addr_next      = addr_reg + ADDR_W'({burst_reg, 3'b000});
          remaining_next = remaining_reg - LEN_W'(burst_reg);
          if (remaining_next != '0) begin
            load_burst = 1'b1;
            state_next = ADDR;
          end else begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (!out_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      burst_reg     <= 4'd0;
      beat_cnt_reg  <= 4'd0;
      out_cnt_reg   <= 4'd0;
      err_reg       <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      remaining_reg <= remaining_next;
      if (load_burst) burst_reg <= beats_next;
      if (state_reg == ADDR && m_arready) beat_cnt_reg <= 4'd0;
      else if (r_hs)                      beat_cnt_reg <= beat_cnt_reg + 4'd1;
      // The new length is latched at ADDR entry, but out_cnt only takes it
      // together with the first word of that burst: the last word of the
      // previous burst can still be held in the output stage at that point.
      if (r_hs && beat_cnt_reg == 4'd0) out_cnt_reg <= burst_reg;
      if (clr_err) begin
        err_reg <= 1'b0;
      end else if (r_hs && (m_rresp != AXI_RESP_OKAY || m_rlast != last_beat)) begin
        err_reg <= 1'b1;
      end
      done_reg <= (state_reg == DONE) && !out_valid;
    end
  end

  hp_out_reg u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (r_hs),
    .load_data (m_rdata),
    .out_full  (out_full),
    .ready     (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign err       = err_reg;
  assign m_arvalid = (state_reg == ADDR);
  assign m_araddr  = addr_reg;
  assign m_arlen   = m_arvalid ? {4'd0, burst_reg - 4'd1} : 8'd0;
  assign m_arsize  = AXI_SIZE_8B;
  assign m_arburst = AXI_BURST_INCR;
  assign m_rready  = (state_reg == DATA) && out_ready;
  assign out_cnt   = out_cnt_reg;

endmodule

// File: tb/tb_hp_burst_reader.sv
// Scoreboard bench for hp_burst_reader: directed transfers push expected AR
// requests and output words into queues; monitors pop and compare on each
// AR handshake and each consumed output word. A behavioural AXI slave
// returns data {~addr, addr} for every beat.
module tb_hp_burst_reader;

  localparam int ADDR_W    = 32;
  localparam int MAX_BURST = 8;
  localparam int LEN_W     = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  total_beats = '0;
  logic              busy, done, err;
  logic [ADDR_W-1:0] m_araddr;
  logic [7:0]        m_arlen;
  logic [2:0]        m_arsize;
  logic [1:0]        m_arburst;
  logic              m_arvalid;
  logic              m_arready;
  logic [63:0]       m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rlast;
  logic              m_rvalid;
  logic              m_rready;
  logic              out_valid;
  logic [3:0]        out_cnt;
  logic [63:0]       out_data;
  logic              out_full;

  always #5 clk = ~clk;

  hp_burst_reader #(.ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .total_beats(total_beats), .busy(busy), .done(done), .err(err),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .out_valid(out_valid),
    .out_cnt(out_cnt), .out_data(out_data), .out_full(out_full)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [63:0] exp_data_q[$];
  logic [3:0]  exp_cnt_q[$];
  logic [31:0] exp_ar_addr_q[$];
  logic [7:0]  exp_ar_len_q[$];

  int done_cnt  = 0;
  bit full_mode = 1'b0;
  int inj_beat  = -1;
  int gbeat     = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] word_of(input logic [31:0] a);
    return {~a, a};
  endfunction

  // AXI slave: handshakes are sampled mid-cycle, responses driven after the edge.
  initial begin : slave
    logic        hs_ar, hs_r;
    logic [31:0] ar_a, s_addr;
    logic [7:0]  ar_l;
    int          s_len, s_idx;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;
    s_addr = '0; s_len = 0; s_idx = 0;
    forever begin
      @(negedge clk);
      hs_ar = m_arvalid && m_arready;
      hs_r  = m_rvalid && m_rready;
      ar_a  = m_araddr;
      ar_l  = m_arlen;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = '0;
      end else if (hs_ar || hs_r) begin
        if (hs_ar) begin
          s_addr = ar_a; s_len = int'(ar_l) + 1; s_idx = 0; m_arready = 1'b0;
        end else begin
          gbeat++;
          s_idx++;
        end
        if (s_idx == s_len) begin
          m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = '0; m_arready = 1'b1;
        end else begin
          m_rvalid = 1'b1;
          m_rdata  = word_of(s_addr + 32'(8 * s_idx));
          m_rlast  = (s_idx == s_len - 1);
          m_rresp  = (gbeat == inj_beat) ? 2'b10 : 2'b00;
        end
      end else if (!m_rvalid) begin
        m_arready = 1'b1;
      end
    end
  end

  // Downstream back-pressure: 3 cycles full, 1 cycle free while full_mode is set.
  initial begin : fullgen
    int ph;
    ph = 0;
    out_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (full_mode) begin
        out_full = (ph < 3);
        ph = (ph + 1) % 4;
      end else begin
        out_full = 1'b0;
        ph = 0;
      end
    end
  end

  // Monitor: AR requests, consumed words, hold-while-full behaviour, done pulses.
  initial begin : monitor
    bit          prev_hold;
    logic [63:0] prev_data;
    prev_hold = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
      end else begin
        if (m_arvalid && m_arready) begin
          if (exp_ar_addr_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL ar_unexpected: got addr 0x%0h len %0d, expected no AR", m_araddr, m_arlen);
          end else begin
            chk("ar_addr", m_araddr, exp_ar_addr_q.pop_front());
            chk("ar_len", m_arlen, exp_ar_len_q.pop_front());
          end
        end
        if (prev_hold) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, prev_data);
        end
        if (out_valid && out_full) chk("rready_when_full", m_rready, 0);
        if (out_valid && !out_full) begin
          if (exp_data_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL word_unexpected: got 0x%0h, expected no word", out_data);
          end else begin
            chk("word_data", out_data, exp_data_q.pop_front());
            chk("word_cnt", out_cnt, exp_cnt_q.pop_front());
          end
        end
        if (done) done_cnt++;
        prev_hold = out_valid && out_full;
        prev_data = out_data;
      end
    end
  end

  task automatic push_expect(input logic [31:0] base, input int b0, input int b1, input int b2);
    int          bl[3];
    logic [31:0] a;
    bl = '{b0, b1, b2};
    a  = base & 32'hFFFF_FFF8;
    for (int i = 0; i < 3; i++) begin
      if (bl[i] > 0) begin
        exp_ar_addr_q.push_back(a);
        exp_ar_len_q.push_back(8'(bl[i] - 1));
        for (int k = 0; k < bl[i]; k++) begin
          exp_data_q.push_back(word_of(a + 32'(8 * k)));
          exp_cnt_q.push_back(4'(bl[i]));
        end
        a = a + 32'(8 * bl[i]);
      end
    end
  endtask

  task automatic issue_start(input logic [31:0] base, input int n);
    @(posedge clk);
    #1;
    start = 1'b1; base_addr = base; total_beats = 16'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_xfer(input logic [31:0] base, input int n, input int b0, input int b1,
                          input int b2, input bit exp_err, input bit toggle, input bit poke);
    int c;
    push_expect(base, b0, b1, b2);
    done_cnt = 0;
    gbeat    = 0;
    issue_start(base, n);
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    chk("arvalid_after_start", m_arvalid, (n != 0));
    chk("err_cleared", err, 0);
    chk("done_early", done, 0);
    if (n == 0) begin
      @(negedge clk);
      chk("zero_done_timing", done, 1);
    end
    if (poke) begin
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1; base_addr = 32'h5000_0000; total_beats = 16'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    if (toggle) begin
      repeat (4) @(posedge clk);
      #1;
      full_mode = 1'b1;
    end
    c = 0;
    while (c < 3000 && done_cnt == 0) begin
      @(negedge clk);
      c++;
    end
    full_mode = 1'b0;
    chk("done_seen", (done_cnt != 0), 1);
    repeat (4) @(negedge clk);
    chk("done_once", done_cnt, 1);
    chk("err_final", err, exp_err);
    chk("busy_final", busy, 0);
    chk("words_left", exp_data_q.size(), 0);
    chk("ars_left", exp_ar_addr_q.size(), 0);
    exp_data_q.delete(); exp_cnt_q.delete(); exp_ar_addr_q.delete(); exp_ar_len_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_arvalid"}, m_arvalid, 0);
    chk({tag, "_araddr"}, m_araddr, 0);
    chk({tag, "_arlen"}, m_arlen, 0);
    chk({tag, "_arsize"}, m_arsize, 3'b011);
    chk({tag, "_arburst"}, m_arburst, 2'b01);
    chk({tag, "_rready"}, m_rready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_cnt"}, out_cnt, 0);
    chk({tag, "_out_data"}, out_data, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int c;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 20 words: 8 + 8 + 4, plus an ignored start while busy
    run_xfer(32'h1000_0000, 20, 8, 8, 4, 1'b0, 1'b0, 1'b1);
    // 4 KB split: 4 words up to 0x1000_1000, then 6
    run_xfer(32'h1000_0FE0, 10, 4, 6, 0, 1'b0, 1'b0, 1'b0);
    // back-pressure 3 high / 1 low from mid-burst
    run_xfer(32'h3000_0000, 8, 8, 0, 0, 1'b0, 1'b1, 1'b0);
    // SLVERR on the third beat, low address bits ignored
    inj_beat = 2;
    run_xfer(32'h2000_0105, 8, 8, 0, 0, 1'b1, 1'b0, 1'b0);
    inj_beat = -1;
    // next start clears err; single word up to the page end, then 2
    run_xfer(32'h0000_0FF8, 3, 1, 2, 0, 1'b0, 1'b0, 1'b0);
    // zero-length transfer
    run_xfer(32'h7000_0000, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

    // reset during burst 2
    push_expect(32'h4000_0000, 8, 8, 4);
    gbeat = 0;
    issue_start(32'h4000_0000, 20);
    c = 0;
    while (c < 500 && exp_ar_addr_q.size() > 1) begin
      @(negedge clk);
      c++;
    end
    chk("second_ar_seen", exp_ar_addr_q.size(), 1);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_data_q.delete(); exp_cnt_q.delete(); exp_ar_addr_q.delete(); exp_ar_len_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_xfer(32'h6000_0000, 20, 8, 8, 4, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
